// File: rtl/ring_slide_seq_pkg.sv
// Shared types and constants for the per-cluster ring slide sequencer.
package ring_slide_seq_pkg;

  localparam int RingNrLanes   = 4;
  localparam int RingDataWidth = 64;
  localparam int RingMaxBeats  = 256;
  localparam int RingLenWidth  = $clog2(RingMaxBeats + 1);

  typedef logic [RingDataWidth-1:0] elen_t;

  // One slide/reduction transfer request; len counts lane beats.
  typedef struct packed {
    logic                    dir;
    logic                    bypass;
    logic [RingLenWidth-1:0] len;
  } ring_slide_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONF = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } ring_seq_state_e;

  // True when a requested beat count fits the configured maximum.
  function automatic logic len_in_range(input logic [RingLenWidth-1:0] len,
                                        input int max_beats);
    return int'(len) <= max_beats;
  endfunction

endpackage

// File: rtl/ring_slide_seq_deser.sv
// Ring-word to lane-beat deserializer: collects NrLanes words from the
// router into one beat and holds it until the lane side takes it.
module ring_word_deser
  import ring_slide_seq_pkg::*;
#(
  parameter int NrLanes   = RingNrLanes,
  parameter int DataWidth = RingDataWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [DataWidth-1:0]         sldu_i,
  input  logic                         sldu_valid_i,
  output logic                         sldu_ready_o,
  output logic [NrLanes*DataWidth-1:0] rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic                         beat_done_o
);

  localparam int IdxWidth = (NrLanes > 1) ? $clog2(NrLanes) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrLanes - 1);

  logic [NrLanes*DataWidth-1:0] slots_q;
  logic [IdxWidth-1:0]          rx_idx_q;
  logic                         rx_full_q;
  logic                         word_fire;

  // No intake while a completed beat is waiting: slots must stay stable.
  assign sldu_ready_o = en_i && !rx_full_q;
  assign word_fire    = sldu_valid_i && sldu_ready_o;
  assign beat_done_o  = word_fire && (rx_idx_q == LastIdx);
  assign rx_data_o    = slots_q;
  assign rx_valid_o   = rx_full_q;

  // Slot fill, index wrap and full-flag handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q   <= '0;
      rx_idx_q  <= '0;
      rx_full_q <= 1'b0;
    end else begin
      if (word_fire) begin
        slots_q[DataWidth*int'(rx_idx_q) +: DataWidth] <= sldu_i;
        rx_idx_q <= beat_done_o ? '0 : rx_idx_q + IdxWidth'(1);
      end
      if (beat_done_o) begin
        rx_full_q <= 1'b1;
      end else if (rx_full_q && rx_ready_i) begin
        rx_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ring_slide_seq.sv
// Sequencer between the lane-side slide unit and the inter-cluster ring
// router: configures the router, serializes lane beats into ring words and
// reassembles returned words into lane beats.
module ring_slide_seq
  import ring_slide_seq_pkg::*;
#(
  parameter int NrLanes   = RingNrLanes,
  parameter int DataWidth = RingDataWidth,
  parameter int MaxBeats  = RingMaxBeats
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  ring_slide_req_t              req_i,
  input  logic [NrLanes*DataWidth-1:0] tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic                         router_dir_o,
  output logic                         router_bypass_o,
  output logic                         router_conf_valid_o,
  output logic [DataWidth-1:0]         sldu_o,
  output logic                         sldu_valid_o,
  input  logic                         sldu_ready_i,
  input  logic [DataWidth-1:0]         sldu_i,
  input  logic                         sldu_valid_i,
  output logic                         sldu_ready_o,
  output logic [NrLanes*DataWidth-1:0] rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic                         done_o
);

  localparam int LenWidth = RingLenWidth;
  localparam int IdxWidth = (NrLanes > 1) ? $clog2(NrLanes) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrLanes - 1);

  ring_seq_state_e state_q, state_d;

  logic [LenWidth-1:0]          len_q;
  logic [LenWidth-1:0]          tx_beats_q;
  logic [LenWidth-1:0]          rx_beats_q;
  logic                         router_dir_q;
  logic                         router_bypass_q;

  logic [NrLanes*DataWidth-1:0] tx_buf_q;
  logic                         tx_full_q;
  logic [IdxWidth-1:0]          tx_idx_q;

  logic                         req_fire;
  logic                         tx_fire;
  logic                         word_fire;
  logic                         rx_en;
  logic                         rx_beat_done;
  logic                         xfer_done;

  assign req_ready_o         = (state_q == IDLE);
  assign req_fire            = req_valid_i && req_ready_o;
  assign router_conf_valid_o = (state_q == CONF);
  assign done_o              = (state_q == DONE);
  assign router_dir_o        = router_dir_q;
  assign router_bypass_o     = router_bypass_q;

  // The serializer takes a new beat only into an empty buffer, so a freed
  // buffer is refilled one cycle after its last word leaves at the earliest.
  assign tx_ready_o   = (state_q == XFER) && !tx_full_q && (tx_beats_q < len_q);
  assign tx_fire      = tx_valid_i && tx_ready_o;
  assign sldu_valid_o = tx_full_q;
  assign sldu_o       = tx_buf_q[DataWidth*int'(tx_idx_q) +: DataWidth];
  assign word_fire    = sldu_valid_o && sldu_ready_i;

  // Words are still owed exactly while fewer than len beats are complete.
  assign rx_en = (state_q == XFER) && (rx_beats_q < len_q);

  assign xfer_done = (tx_beats_q == len_q) && !tx_full_q &&
                     (rx_beats_q == len_q) && !rx_valid_o;

  // Next-state logic for the request/configure/transfer/complete sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = CONF;
      CONF:    state_d = (router_bypass_q || (len_q == '0)) ? DONE : XFER;
      XFER:    if (xfer_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request latch; router config is held until the next
  // accepted request so the router keeps its last direction after done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      len_q           <= '0;
      router_dir_q    <= 1'b0;
      router_bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        len_q           <= req_i.len;
        router_dir_q    <= req_i.dir;
        router_bypass_q <= req_i.bypass;
      end
    end
  end

  // Beat counters for both directions, restarted by each new request.
  always_ff @(posedge clk_i) begin
    if (rst_i || req_fire) begin
      tx_beats_q <= '0;
      rx_beats_q <= '0;
    end else begin
      if (tx_fire)      tx_beats_q <= tx_beats_q + LenWidth'(1);
      if (rx_beat_done) rx_beats_q <= rx_beats_q + LenWidth'(1);
    end
  end

  // TX serializer: one beat buffer drained word 0 first toward the router.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
      tx_idx_q  <= '0;
    end else if (tx_fire) begin
      tx_buf_q  <= tx_data_i;
      tx_full_q <= 1'b1;
    end else if (word_fire) begin
      if (tx_idx_q == LastIdx) begin
        tx_full_q <= 1'b0;
        tx_idx_q  <= '0;
      end else begin
        tx_idx_q <= tx_idx_q + IdxWidth'(1);
      end
    end
  end

  ring_word_deser #(
    .NrLanes   (NrLanes),
    .DataWidth (DataWidth)
  ) i_deser (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (rx_en),
    .sldu_i       (sldu_i),
    .sldu_valid_i (sldu_valid_i),
    .sldu_ready_o (sldu_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .beat_done_o  (rx_beat_done)
  );

  a_len_in_range: assert property (
    @(posedge clk_i) disable iff (rst_i)
    req_fire |-> len_in_range(req_i.len, MaxBeats)
  );

endmodule

// File: doc/ring_slide_seq.md
Name: ring_slide_seq

Overview:
Per-cluster sequencer between the lane-side slide unit (SLDU) datapath and the inter-cluster ring router.
- Accepts one slide/reduction transfer request at a time and issues the router configuration pulse.
- Serializes NrLanes-wide lane beats into single-word transfers on the router's SLDU input.
- Deserializes words returned by the router back into lane beats, then signals completion.

Parameters:
NrLanes, 4, number of 64-bit words per lane beat.
DataWidth, $bits(elen_t) (64), width of one ring word.
MaxBeats, 256, maximum beats per request; LenWidth = $clog2(MaxBeats+1).

Ports:
clk_i  in  1  clock; the block uses this one clock only.
rst_i  in  1  reset, synchronous, active-high.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request ready; high only in IDLE.
req_i  in  ring_slide_req_t  {dir, bypass, len[LenWidth]}; len is in lane beats.
tx_data_i  in  NrLanes*DataWidth  lane beat to send; word 0 is bits [63:0].
tx_valid_i  in  1  lane beat valid.
tx_ready_o  out  1  lane beat ready.
router_dir_o  out  1  to router dir; 0 = left/slidedown, 1 = right.
router_bypass_o  out  1  to router bypass.
router_conf_valid_o  out  1  to router conf_valid; single-cycle pulse.
sldu_o  out  DataWidth  word to router sldu_i.
sldu_valid_o  out  1  word valid.
sldu_ready_i  in  1  router ready for word.
sldu_i  in  DataWidth  word from router sldu_o.
sldu_valid_i  in  1  word valid.
sldu_ready_o  out  1  ready for word.
rx_data_o  out  NrLanes*DataWidth  reassembled lane beat.
rx_valid_o  out  1  beat valid.
rx_ready_i  in  1  beat ready.
done_o  out  1  single-cycle completion pulse.

Behaviour:
- Reset (rst_i high at clk_i edge):
  - State goes to IDLE.
  - All counters, buffers and flags clear.
  - Every output reads 0, except req_ready_o, which reads 1 because the state is IDLE.
  - A reset during an active transfer discards partial beats and in-flight words; no done_o pulse is issued.
- FSM states are IDLE, CONF, XFER and DONE.
  - IDLE: a request is accepted on req_valid_i && req_ready_o. The block latches dir, bypass and len, then moves to CONF.
  - CONF: router_conf_valid_o is 1 for exactly this cycle. router_dir_o and router_bypass_o are registered from the latched request and hold their value until the next CONF.
    - If bypass=1 or len=0, go to DONE.
    - Otherwise go to XFER.
  - XFER: exit to DONE when tx_beats==len, no serializer word is pending, rx_beats==len, and the final rx beat has been accepted.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- Latency: done_o asserts 2 cycles after acceptance for a bypass or len=0 request.
- TX serializer:
  - Holds one beat buffer plus a word index in the range 0..NrLanes-1.
  - tx_ready_o = XFER && buffer empty && tx_beats<len.
  - Words are emitted on sldu_o in order from index 0 to NrLanes-1.
  - sldu_valid_o stays high, with stable data, until sldu_ready_i is seen.
  - The buffer frees when the last word is accepted. A new beat may be accepted one cycle later (no same-cycle refill).
  - tx_beats increments when a beat is accepted on tx_valid_i && tx_ready_o.
- RX deserializer:
  - sldu_ready_o = XFER && !rx_full && rx_words_remaining>0.
  - Each accepted word is written into slot rx_idx, and rx_idx increments.
  - When slot NrLanes-1 is written: rx_full=1, rx_valid_o=1, rx_idx wraps to 0 and rx_beats increments.
  - rx_full clears on rx_valid_o && rx_ready_i.
  - rx_data_o stays stable while rx_valid_o is high.
- Same-cycle events: TX and RX handshakes are independent and may fire in the same cycle. A req_valid_i arriving during the DONE state waits for IDLE.
- Out of contract:
  - req_i.len>MaxBeats: an assertion flags it.
  - Words arriving on sldu_valid_i outside XFER are not accepted.

Decomposition:
- Add to ara_pkg:
  - ring_slide_req_t packed struct {logic dir; logic bypass; logic [LenWidth-1:0] len;}.
  - ring_seq_state_e enum {IDLE, CONF, XFER, DONE}.
- One sub-module: ring_word_deser, which holds the RX slot buffer, rx_idx, rx_full and the handshake. The serializer stays inline.

Test Plan:
1. NrLanes=4. Request dir=0, bypass=0, len=2. Send tx beats A=[A0..A3], B=[B0..B3]. Hold sldu_ready_i=1 and feed 8 words R0..R7 on sldu_i.
   -> conf pulse with dir=0, bypass=0 one cycle after acceptance.
   -> sldu_o emits A0,A1,A2,A3,B0..B3 in order.
   -> rx beats [R0..R3] and [R4..R7] are delivered.
   -> done_o pulses once.
2. Request bypass=1, len=5.
   -> conf pulse with bypass=1.
   -> done_o 2 cycles after acceptance.
   -> tx_ready_o and sldu_ready_o never assert.
3. Request dir=1, len=1, with sldu_ready_i toggling 1,0,0,1,...
   -> sldu_o shows exactly 4 accepted words in order, with no duplicates.
   -> router_dir_o=1 holds after done_o.
4. Hold rx_ready_i=0 after 4 words arrive.
   -> rx_valid_o=1, sldu_ready_o=0, rx_data_o stable.
   -> releasing rx_ready_i resumes intake the cycle after the handshake.
5. Request len=0, bypass=0.
   -> conf pulse, done_o 2 cycles after acceptance, no tx/rx activity.
6. Assert rst_i mid-XFER after 3 tx words.
   -> next cycle all outputs 0 and req_ready_o=1, no done_o.
   -> a fresh len=1 request then completes correctly.
